mbe_mult_sched: RTL and testbench

Two-requester scheduler that time-shares one combinational Modified-Booth multiplier (DW×DW → 2·DW, signed two's complement) between two clients. It arbitrates round-robin and registers operands in front of the multiplier and the product behind it, forming a 2-stage pipeline. It routes each product back to the requester that issued it, with valid/ready backpressure on both sides. It sits between client datapaths and the shared multiplier instance, whose `in1`/`in2`/`sig_out` connect to `mul_a`/`mul_b`/`mul_p`.

---
 rtl/mbe_mult_sched.sv | 99 +++++++++
 tb/tb_mbe_mult_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbe_mult_sched.sv
// Two-requester round-robin scheduler in front of one shared signed multiplier.
// S1 registers the granted operands and drives the multiplier. S2 registers
// the product and returns it to the port that issued the request.
module mbe_mult_sched #(
  parameter int unsigned DW = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [2*DW-1:0] rsp0_p,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [2*DW-1:0] rsp1_p,
  output logic [DW-1:0]   mul_a,
  output logic [DW-1:0]   mul_b,
  input  logic [2*DW-1:0] mul_p,
  output logic            busy
);

  logic            s1_v_q, s1_own_q;
  logic [DW-1:0]   s1_a_q, s1_b_q;
  logic            s2_v_q, s2_own_q;
  logic [2*DW-1:0] s2_p_q;
  logic            last_q;

  logic s2_adv, s2_free, s1_adv, s1_free;
  logic grant0, grant1, acc0, acc1;

  // Pipeline advance conditions and round-robin grant.
  always_comb begin
    s2_adv  = s2_v_q & (s2_own_q ? rsp1_ready : rsp0_ready);
    s2_free = ~s2_v_q | s2_adv;
    s1_adv  = s1_v_q & s2_free;
    s1_free = ~s1_v_q | s1_adv;
    // Under contention the port that was not granted last time wins.
    grant0  = req0_valid & (~req1_valid | last_q);
    grant1  = req1_valid & (~req0_valid | ~last_q);
    // Ready is forced low while reset is asserted.
    req0_ready = grant0 & s1_free & ~RST;
    req1_ready = grant1 & s1_free & ~RST;
    acc0    = req0_valid & req0_ready;
    acc1    = req1_valid & req1_ready;
  end

  // Stage 1: capture the granted request; drain into S2 when it frees.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_v_q   <= 1'b0;
      s1_own_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      last_q   <= 1'b1;
    end else if (acc0 | acc1) begin
      s1_v_q   <= 1'b1;
      s1_own_q <= acc1;
      s1_a_q   <= acc1 ? req1_a : req0_a;
      s1_b_q   <= acc1 ? req1_b : req0_b;
      last_q   <= acc1;
    end else if (s1_adv) begin
      s1_v_q   <= 1'b0;
    end
  end

  // Stage 2: capture the product when S1 advances; clear when consumed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_v_q   <= 1'b0;
      s2_own_q <= 1'b0;
      s2_p_q   <= '0;
    end else if (s1_adv) begin
      s2_v_q   <= 1'b1;
      s2_own_q <= s1_own_q;
      s2_p_q   <= mul_p;
    end else if (s2_adv) begin
      s2_v_q   <= 1'b0;
    end
  end

  // Output routing: both ports see the same product, qualified by owner.
  always_comb begin
    mul_a      = s1_a_q;
    mul_b      = s1_b_q;
    rsp0_valid = s2_v_q & ~s2_own_q;
    rsp1_valid = s2_v_q & s2_own_q;
    rsp0_p     = s2_p_q;
    rsp1_p     = s2_p_q;
    busy       = s1_v_q | s2_v_q;
  end

endmodule

// File: tb/tb_mbe_mult_sched.sv
// Randomized and directed bench for mbe_mult_sched against a queue-based model.
module tb_mbe_mult_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [63:0] rsp0_p, rsp1_p, mul_p;
  logic [31:0] mul_a, mul_b;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  // Stand-in for the shared multiplier.
  assign mul_p = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});

  mbe_mult_sched dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight requests in acceptance order (at most two).
  typedef struct {
    bit          own;
    logic [63:0] p;
    int          t;
  } ent_t;
  ent_t q[$];
  bit   last_m  = 1'b1;
  int   cyc     = 0;
  bit   started = 1'b0;

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = longint'(signed'(a));
    y = longint'(signed'(b));
    return x * y;
  endfunction

  // Two in flight means the older one is already in the output stage; a lone
  // request reaches the output one cycle after acceptance.
  function automatic void model_comb(output bit r0, output bit r1, output bit vis,
                                     output bit cons);
    bit free, g0, g1;
    vis  = (q.size() == 2) || (q.size() == 1 && q[0].t != cyc);
    cons = vis && (q[0].own ? rsp1_ready : rsp0_ready);
    free = (q.size() < 2) || cons;
    g0   = req0_valid && (!req1_valid || last_m);
    g1   = req1_valid && (!req0_valid || !last_m);
    r0   = g0 && free && !RST;
    r1   = g1 && free && !RST;
  endfunction

  // Model state update on each rising edge.
  always @(posedge CLK) begin
    bit r0, r1, vis, cons;
    model_comb(r0, r1, vis, cons);
    cyc++;
    if (RST) begin
      q.delete();
      last_m = 1'b1;
    end else begin
      if (cons) void'(q.pop_front());
      if (r0) begin
        q.push_back('{own: 1'b0, p: prod(req0_a, req0_b), t: cyc});
        last_m = 1'b0;
      end else if (r1) begin
        q.push_back('{own: 1'b1, p: prod(req1_a, req1_b), t: cyc});
        last_m = 1'b1;
      end
    end
    started = 1'b1;
  end

  // Cycle-by-cycle comparison of every handshake output against the model.
  always @(negedge CLK) begin
    bit r0, r1, vis, cons;
    if (started) begin
      model_comb(r0, r1, vis, cons);
      check("req0_ready", 64'(req0_ready), 64'(r0));
      check("req1_ready", 64'(req1_ready), 64'(r1));
      check("rsp0_valid", 64'(rsp0_valid), 64'(vis && !q[0].own));
      check("rsp1_valid", 64'(rsp1_valid), 64'(vis && q[0].own));
      check("busy", 64'(busy), 64'(q.size() != 0));
      if (vis) begin
        if (q[0].own) check("rsp1_p", rsp1_p, q[0].p);
        else          check("rsp0_p", rsp0_p, q[0].p);
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // One reset edge, then check the flushed state.
  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    @(posedge CLK);
    #1;
  endtask

  // Isolated request on one port with a fixed expected product and latency.
  task automatic one_op(input bit port, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    bit acc = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req0_valid = !port; req0_a = a; req0_b = b;
    req1_valid = port;  req1_a = a; req1_b = b;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge CLK);
      acc = port ? req1_ready : req0_ready;
      @(posedge CLK);
      #1;
    end
    if (!acc) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge CLK);
    check({tag, "_t1_valid"}, 64'(port ? rsp1_valid : rsp0_valid), 64'd0);
    check({tag, "_t1_busy"}, 64'(busy), 64'd1);
    @(negedge CLK);
    check({tag, "_t2_valid"}, 64'(port ? rsp1_valid : rsp0_valid), 64'd1);
    check({tag, "_t2_other"}, 64'(port ? rsp0_valid : rsp1_valid), 64'd0);
    check({tag, "_t2_busy"}, 64'(busy), 64'd1);
    check({tag, "_p"}, port ? rsp1_p : rsp0_p, exp);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge CLK);
    #1;
    do_reset();
    check("rst_rsp0_p", rsp0_p, 64'd0);
    check("rst_rsp1_p", rsp1_p, 64'd0);

    // Simultaneous first request after reset: port 0 first, then port 1.
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4;
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd6;
    @(negedge CLK);
    check("sim_first_r0", 64'(req0_ready), 64'd1);
    check("sim_first_r1", 64'(req1_ready), 64'd0);
    @(posedge CLK);
    #1;
    req0_valid = 1'b0;
    @(negedge CLK);
    check("sim_second_r1", 64'(req1_ready), 64'd1);
    @(posedge CLK);
    #1;
    req1_valid = 1'b0;
    @(negedge CLK);
    check("sim_rsp0_valid", 64'(rsp0_valid), 64'd1);
    check("sim_rsp0_p", rsp0_p, 64'd12);
    @(negedge CLK);
    check("sim_rsp1_valid", 64'(rsp1_valid), 64'd1);
    check("sim_rsp1_p", rsp1_p, 64'd30);
    idle();

    one_op(1'b0, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, "single");
    one_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_min");
    one_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "max_min");
    one_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, "neg1_neg1");
    one_op(1'b0, 32'h0, 32'h1234_5678, 64'd0, "zero");

    // Sustained contention: both ports valid, distinct operands every cycle.
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1; req0_a = 32'(i + 1);  req0_b = 32'(100 + i);
      req1_valid = 1'b1; req1_a = 32'(-i - 7); req1_b = 32'(200 + i);
      @(posedge CLK);
      #1;
    end
    idle();

    // Backpressure on port 0 while it streams.
    req0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_a = pick(); req0_b = pick();
      rsp0_ready = !(i >= 1 && i <= 3);
      @(posedge CLK);
      #1;
    end
    idle();

    // Reset with both stages full, then a contended request.
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge CLK);
    check("post_rst_grant0", 64'(req0_ready), 64'd1);
    @(posedge CLK);
    #1;
    idle();

    // Random traffic with random backpressure.
    for (int i = 0; i < 2000; i++) begin
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      req0_a = pick(); req0_b = pick();
      req1_a = pick(); req1_b = pick();
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      if (i == 1200) RST = 1'b1;
      else           RST = 1'b0;
      @(posedge CLK);
      #1;
    end
    RST = 1'b0;
    idle();
    @(negedge CLK);
    check("final_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
